// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the EX/MEM/WB control pipeline: ALU codes, ALUOp/funct
// encodings, per-stage control bundles and their bubble values.
package ctrl_pipe_pkg;

  localparam int ALUOP_W   = 2;
  localparam int FUNCT_W   = 6;
  localparam int CTL_W_DEF = 4;

  localparam logic [CTL_W_DEF-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTL_W_DEF-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTL_W_DEF-1:0] ALU_AND = 4'b0000;
  localparam logic [CTL_W_DEF-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTL_W_DEF-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTL_W_DEF-1:0] ALU_ILL = 4'b1111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 memto_reg;
    logic                 branch;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_dst;
    logic                 alu_src;
    logic [CTL_W_DEF-1:0] alu_ctl;
    logic                 illegal;
  } ex_ctrl_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic memto_reg;
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic memto_reg;
  } wb_ctrl_t;

  // Reset clears everything; a bubble differs only in carrying the add code.
  localparam ex_ctrl_t EX_RESET = '0;
  localparam ex_ctrl_t EX_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, memto_reg: 1'b0,
                                     branch: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                     reg_dst: 1'b0, alu_src: 1'b0, alu_ctl: ALU_ADD,
                                     illegal: 1'b0};
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  function automatic mem_ctrl_t ex_to_mem(input ex_ctrl_t e);
    return '{valid: e.valid, reg_write: e.reg_write, memto_reg: e.memto_reg,
             branch: e.branch, mem_read: e.mem_read, mem_write: e.mem_write};
  endfunction

  function automatic wb_ctrl_t mem_to_wb(input mem_ctrl_t m);
    return '{valid: m.valid, reg_write: m.reg_write, memto_reg: m.memto_reg};
  endfunction

endpackage

// File: rtl/ctrl_pipe_ex_mem_wb_alu_control.sv
// Combinational ALU control: maps ALUOp and funct to an ALU operation code,
// flagging encodings that have no defined operation.
module alu_control
  import ctrl_pipe_pkg::*;
(
  input  logic [ALUOP_W-1:0]   i_aluop,
  input  logic [FUNCT_W-1:0]   i_funct,
  output logic [CTL_W_DEF-1:0] o_alu_ctl,
  output logic                 o_illegal
);

  always_comb begin
    o_alu_ctl = ALU_ILL;
    o_illegal = 1'b1;
    case (i_aluop)
      ALUOP_ADD: begin
        o_alu_ctl = ALU_ADD;
        o_illegal = 1'b0;
      end
      ALUOP_SUB: begin
        o_alu_ctl = ALU_SUB;
        o_illegal = 1'b0;
      end
      ALUOP_FUNCT: begin
        o_illegal = 1'b0;
        case (i_funct)
          FUNCT_ADD: o_alu_ctl = ALU_ADD;
          FUNCT_SUB: o_alu_ctl = ALU_SUB;
          FUNCT_AND: o_alu_ctl = ALU_AND;
          FUNCT_OR:  o_alu_ctl = ALU_OR;
          FUNCT_SLT: o_alu_ctl = ALU_SLT;
          default: begin
            o_alu_ctl = ALU_ILL;
            o_illegal = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_ex_mem_wb.sv
// ID->EX->MEM->WB control-bundle pipeline with stall bubbles and branch flush.
// Define CTRL_PIPE_STATS_EN to build saturating bubble/flush statistics counters.
module ctrl_pipe_ex_mem_wb
  import ctrl_pipe_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int ALU_CTL_W = CTL_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_RegWrite,
  input  logic                 id_MemtoReg,
  input  logic                 id_Branch,
  input  logic                 id_MemRead,
  input  logic                 id_MemWrite,
  input  logic                 id_RegDst,
  input  logic                 id_ALUSrc,
  input  logic [1:0]           id_ALUOp,
  input  logic [5:0]           id_funct,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic                 mem_valid,
  output logic                 wb_valid,
  output logic                 ex_RegDst,
  output logic                 ex_ALUSrc,
  output logic [ALU_CTL_W-1:0] ex_alu_ctl,
  output logic                 ex_alu_illegal,
  output logic                 ex_MemRead,
  output logic                 mem_Branch,
  output logic                 mem_MemRead,
  output logic                 mem_MemWrite,
  output logic                 wb_RegWrite,
  output logic                 wb_MemtoReg,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  ex_ctrl_t  r_ex;
  mem_ctrl_t r_mem;
  wb_ctrl_t  r_wb;
  ex_ctrl_t  w_id_ctrl;
  logic [CTL_W_DEF-1:0] w_alu_ctl;
  logic                 w_alu_illegal;

  alu_control u_alu_control (
    .i_aluop   (id_ALUOp),
    .i_funct   (id_funct),
    .o_alu_ctl (w_alu_ctl),
    .o_illegal (w_alu_illegal)
  );

  // An invalid ID slot becomes a bubble regardless of what its control bits say.
  always_comb begin
    w_id_ctrl = EX_BUBBLE;
    if (id_valid) begin
      w_id_ctrl = '{valid: 1'b1, reg_write: id_RegWrite, memto_reg: id_MemtoReg,
                    branch: id_Branch, mem_read: id_MemRead, mem_write: id_MemWrite,
                    reg_dst: id_RegDst, alu_src: id_ALUSrc, alu_ctl: w_alu_ctl,
                    illegal: w_alu_illegal};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex  <= EX_RESET;
      r_mem <= MEM_BUBBLE;
      r_wb  <= WB_BUBBLE;
    end else if (flush) begin
      r_ex  <= EX_BUBBLE;
      r_mem <= MEM_BUBBLE;
      r_wb  <= mem_to_wb(r_mem);
    end else if (stall) begin
      r_ex  <= EX_BUBBLE;
      r_mem <= ex_to_mem(r_ex);
      r_wb  <= mem_to_wb(r_mem);
    end else begin
      r_ex  <= w_id_ctrl;
      r_mem <= ex_to_mem(r_ex);
      r_wb  <= mem_to_wb(r_mem);
    end
  end

  assign ex_valid       = r_ex.valid;
  assign ex_RegDst      = r_ex.reg_dst;
  assign ex_ALUSrc      = r_ex.alu_src;
  assign ex_alu_ctl     = r_ex.alu_ctl;
  assign ex_alu_illegal = r_ex.illegal;
  assign ex_MemRead     = r_ex.mem_read;
  assign mem_valid      = r_mem.valid;
  assign mem_Branch     = r_mem.branch;
  assign mem_MemRead    = r_mem.mem_read;
  assign mem_MemWrite   = r_mem.mem_write;
  assign wb_valid       = r_wb.valid;
  assign wb_RegWrite    = r_wb.reg_write;
  assign wb_MemtoReg    = r_wb.memto_reg;

`ifdef CTRL_PIPE_STATS_EN
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // A stall coinciding with a flush is not a bubble of its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
      if (stall && !flush && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule
